phase_packer: RTL

Downstream stage of the phase-difference chain. Counts enabled samples to locate each completed 2^K-sample phase mean, snapshots the six signed 16-bit mean phase differences and serialises them as a framed byte stream over a valid/ready interface toward the host link (UART/FIFO bridge). One frame per completed mean window; windows completing while a frame is in flight are dropped and counted.

---
 rtl/phase_packer_pkg.sv | 23 ++
 rtl/phase_window_timer.sv | 58 +++++
 rtl/phase_packer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/phase_packer_pkg.sv
// Shared types and constants for the phase_packer frame serialiser.
// Frame length depends on PHASE_PACKER_CHKSUM_EN (15 bytes with checksum, 14 without).
package phase_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  localparam int FRAME_LEN_CHK   = 15;
  localparam int FRAME_LEN_NOCHK = 14;
  localparam int DATA_BYTES      = 12;
  localparam int K_CLAMP         = 15;

  // Window exponents above K_CLAMP behave as K_CLAMP.
  function automatic logic [3:0] clamp_k(input logic [9:0] k);
    return (k > 10'(K_CLAMP)) ? 4'(K_CLAMP) : k[3:0];
  endfunction

endpackage

// File: rtl/phase_window_timer.sv
// Counts enabled samples to find each completed 2^K window, then delays
// the terminal pulse by CAPTURE_DELAY cycles to produce the snapshot strobe.
module phase_window_timer
  import phase_packer_pkg::*;
#(
  parameter int CAPTURE_DELAY = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] k,
  output logic       snapshot
);

  logic [3:0]  keff;
  logic [15:0] limit;
  logic [15:0] count;
  logic        terminal;

  assign keff     = clamp_k(k);
  assign limit    = (16'd1 << keff) - 16'd1;
  assign terminal = enable && (count == limit);

  // A limit lowered below the current count is only reached after the natural 16-bit wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? 16'd0 : count + 16'd1;
    end
  end

  generate
    if (CAPTURE_DELAY == 0) begin : g_nodly
      assign snapshot = terminal;
    end else begin : g_dly
      logic [15:0] dly;
      logic        armed;

      // A fresh terminal pulse restarts the countdown so only the latest window is captured.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          dly   <= '0;
          armed <= 1'b0;
        end else if (terminal) begin
          dly   <= 16'(CAPTURE_DELAY);
          armed <= 1'b1;
        end else if (armed) begin
          dly <= dly - 16'd1;
          if (dly == 16'd1) armed <= 1'b0;
        end
      end

      assign snapshot = armed && (dly == 16'd1) && !terminal;
    end
  endgenerate

endmodule

// File: rtl/phase_packer.sv
// Snapshots six signed mean phase differences per window and streams them as a
// framed byte sequence; checksum byte present only with PHASE_PACKER_CHKSUM_EN.
module phase_packer
  import phase_packer_pkg::*;
#(
  parameter int         CAPTURE_DELAY = 8,
  parameter logic [7:0] HEADER        = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  K,
  input  logic [15:0] diff_phase_1,
  input  logic [15:0] diff_phase_2,
  input  logic [15:0] diff_phase_3,
  input  logic [15:0] diff_phase_4,
  input  logic [15:0] diff_phase_5,
  input  logic [15:0] diff_phase_6,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic        overrun
);

  state_t             state;
  logic [3:0]         idx;
  logic [7:0]         seq;
  logic [7:0]         chk;
  logic signed [15:0] snap_p0 [6];
  logic [7:0]         data_bytes [DATA_BYTES];
  logic [3:0]         nidx;
  logic [7:0]         nxt_byte;
  logic               snapshot;
  logic               hs;
  logic               last_byte;
  logic               accept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  phase_window_timer #(
    .CAPTURE_DELAY(CAPTURE_DELAY)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .k       (K),
    .snapshot(snapshot)
  );

  assign hs   = tx_valid && tx_ready;
  assign busy = (state != ST_IDLE);

`ifdef PHASE_PACKER_CHKSUM_EN
  assign last_byte = (state == ST_CHK);
`else
  assign last_byte = (state == ST_DATA) && (idx == 4'(DATA_BYTES - 1));
`endif

  // A window may start a frame when idle or exactly as the previous frame's last byte leaves.
  assign accept = snapshot && ((state == ST_IDLE) || (last_byte && hs));

  always_comb begin
    for (int j = 0; j < 6; j++) begin
      data_bytes[2*j]   = snap_p0[j][15:8];
      data_bytes[2*j+1] = snap_p0[j][7:0];
    end
    nidx     = (state == ST_DATA) ? idx + 4'd1 : 4'd0;
    nxt_byte = (nidx < 4'(DATA_BYTES)) ? data_bytes[nidx] : 8'h00;
  end

  // Stage p0: snapshot of the phase inputs
  always_ff @(posedge clock) begin
    if (accept) begin
      snap_p0[0] <= diff_phase_1;
      snap_p0[1] <= diff_phase_2;
      snap_p0[2] <= diff_phase_3;
      snap_p0[3] <= diff_phase_4;
      snap_p0[4] <= diff_phase_5;
      snap_p0[5] <= diff_phase_6;
    end
  end

  // Frame FSM: each byte is registered one cycle ahead of the state that presents it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      seq      <= '0;
      chk      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      drop_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (snapshot && !accept) begin
        overrun  <= 1'b1;
        drop_cnt <= sat_inc8(drop_cnt);
      end
      if (last_byte && hs) seq <= seq + 8'd1;

      if (accept) begin
        state    <= ST_HDR;
        tx_data  <= HEADER;
        tx_valid <= 1'b1;
      end else if (last_byte && hs) begin
        state    <= ST_IDLE;
        tx_valid <= 1'b0;
      end else if (hs) begin
        unique case (state)
          ST_HDR: begin
            state   <= ST_SEQ;
            tx_data <= seq;
            chk     <= seq;
          end
          ST_SEQ: begin
            state   <= ST_DATA;
            idx     <= 4'd0;
            tx_data <= nxt_byte;
            chk     <= chk ^ nxt_byte;
          end
          ST_DATA: begin
            if (idx == 4'(DATA_BYTES - 1)) begin
`ifdef PHASE_PACKER_CHKSUM_EN
              state   <= ST_CHK;
              tx_data <= chk;
`else
              state    <= ST_IDLE;
              tx_valid <= 1'b0;
`endif
            end else begin
              idx     <= nidx;
              tx_data <= nxt_byte;
              chk     <= chk ^ nxt_byte;
            end
          end
          default: begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
